fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Front-end fetch sequencer: generates the sequential fetch PC, issues I-cache requests and pairs
//  in-order responses with their PCs. Pushes instr/pc into the fetch queue, sized by credit so a
//  push is never dropped. On a branch-mispredict redirect it flushes the fetch queue, discards
//  stale in-flight responses and restarts at the target. Sits between the I-cache and fetch queue.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  QDEPTH    8              fetch-queue depth; credit limit for requests
//  MAX_OUT   2              max outstanding I-cache requests; size of internal pending-PC FIFO
// PORTS
//  clk              in   1   clock, all state on posedge
//  rst_n            in   1   asynchronous active-low reset
//  fetch_en         in   1   1 = allow new requests
//  redirect_valid   in   1   mispredict redirect strobe
//  redirect_pc      in   32  redirect target
//  icache_req_valid out  1   request valid
//  icache_req_ready in   1   I-cache accepts request
//  icache_req_addr  out  32  request address (word aligned)
//  icache_resp_valid in  1   response valid; responses return in request order
//  icache_resp_instr in  32  response instruction
//  fq_push_en       out  1   push to fetch queue
//  fq_instr         out  32  instruction to push
//  fq_pc            out  32  PC to push
//  fq_pop_en        in   1   fetch-queue pop; counted only when fq_empty==0
//  fq_empty         in   1   fetch-queue empty
//  fq_flush         out  1   fetch-queue flush pulse
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, req_pc=RESET_PC, occ=0, outstanding=0, drop_cnt=0.
//   Outputs: icache_req_valid=0, fq_push_en=0, fq_flush=0, icache_req_addr=RESET_PC.
//   Reset mid-operation discards all in-flight state. Late responses after reset are not pushed.
//  FSM, registered: IDLE, FETCH, REDIRECT.
//   IDLE->FETCH when fetch_en=1. FETCH->IDLE when fetch_en=0.
//   Any state->REDIRECT when redirect_valid=1; redirect has priority over fetch_en.
//   REDIRECT->FETCH (fetch_en=1) or IDLE (fetch_en=0) after one cycle.
//  Credit: live = outstanding - drop_cnt. credit_ok = (occ + live < QDEPTH).
//  icache_req_valid = (state==FETCH) && credit_ok && (outstanding < MAX_OUT) && !redirect_valid.
//  icache_req_addr = req_pc.
//  On a request handshake (valid && ready):
//   - req_pc += 4 (32-bit wrap)
//   - req_pc is written to the pending FIFO
//   - outstanding += 1
//  Response, 0-cycle latency to push: pending FIFO head is popped and outstanding -= 1.
//   - If drop_cnt != 0: drop_cnt -= 1, no push.
//   - Else fq_push_en=1, fq_instr=icache_resp_instr, fq_pc=head PC, occ += 1.
//   - Response with outstanding==0 is a protocol error: ignored, assertion fires.
//  occ -= 1 on fq_pop_en && !fq_empty. Same-cycle push and pop leave occ unchanged.
//  Redirect sampled in cycle N:
//   - drop_cnt <= outstanding after cycle-N updates, so responses in N are handled normally.
//   - req_pc <= {redirect_pc[31:2], 2'b00}. occ <= 0.
//   - N+1: state=REDIRECT, fq_flush=1, no request, no push; pops ignored for occ.
//   - N+2: first request at the target, if fetch_en and credit allow.
//   - Back-to-back redirects: the latest target wins and REDIRECT is held one more cycle.
//  Invariant: occ + live <= QDEPTH, so fq_push_en never coincides with queue full.
// TESTING
//  1 Reset: rst_n=0 mid-stream, then release with fetch_en=1.
//    -> first req_addr=0x0; no push; no flush.
//  2 Stream: ready=1, resp 1 cycle later, pop every cycle.
//    -> req addrs 0,4,8,...; fq_pc matches; occ stays <=1.
//  3 Backpressure: no pops, QDEPTH=8.
//    -> exactly 8 pushes (pc 0x0..0x1C); req_valid then stays 0.
//    -> one pop -> exactly one new request at 0x20.
//  4 Redirect with 2 outstanding, redirect_pc=0x103.
//    -> fq_flush for 1 cycle; both stale responses dropped.
//    -> next request 0x100; first push pc=0x100.
//  5 Redirect in the same cycle as a response.
//    -> that response is pushed, then flushed by fq_flush; drop_cnt=outstanding-1.
//  6 fetch_en=0 with 2 outstanding.
//    -> no new requests; both responses pushed; state=IDLE.

Source files
------------

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - front-end fetch sequencer between the I-cache and the fetch queue
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 8,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        icache_req_valid,
    input  logic        icache_req_ready,
    output logic [31:0] icache_req_addr,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_resp_instr,
    output logic        fq_push_en,
    output logic [31:0] fq_instr,
    output logic [31:0] fq_pc,
    input  logic        fq_pop_en,
    input  logic        fq_empty,
    output logic        fq_flush
);

    localparam int OCC_W = $clog2(QDEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int SUM_W = $clog2(QDEPTH + MAX_OUT + 1);
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    localparam logic [SUM_W-1:0] QDEPTH_S  = SUM_W'(QDEPTH);
    localparam logic [OUT_W-1:0] MAX_OUT_O = OUT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MAX_OUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0]      req_pc;
    logic [OCC_W-1:0] occ;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] drop_cnt;
    logic [OUT_W-1:0] live;
    logic [OUT_W-1:0] out_nxt;
    logic [31:0]      pend_pc [MAX_OUT];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic credit_ok;
    logic req_fire;
    logic resp_fire;
    logic resp_drop;
    logic push;
    logic pop_ok;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a redirect always wins; otherwise fetch_en alone picks FETCH or IDLE.
    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = S_REDIRECT;
        end else begin
            case (state)
                S_IDLE:     state_nxt = fetch_en ? S_FETCH : S_IDLE;
                S_FETCH:    state_nxt = fetch_en ? S_FETCH : S_IDLE;
                S_REDIRECT: state_nxt = fetch_en ? S_FETCH : S_IDLE;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs: request gating by credit and outstanding limit, push straight from the response.
    always_comb begin
        icache_req_valid = (state == S_FETCH) && credit_ok
                           && (outstanding < MAX_OUT_O) && !redirect_valid;
        icache_req_addr  = req_pc;
        fq_push_en       = push;
        fq_instr         = icache_resp_instr;
        fq_pc            = pend_pc[rd_ptr];
        fq_flush         = (state == S_REDIRECT);
    end

    // Credit and handshake decode. Stale responses still in flight do not consume queue credit.
    always_comb begin
        live      = outstanding - drop_cnt;
        credit_ok = (SUM_W'(occ) + SUM_W'(live)) < QDEPTH_S;
        req_fire  = icache_req_valid && icache_req_ready;
        resp_fire = icache_resp_valid && (outstanding != '0);
        resp_drop = resp_fire && (drop_cnt != '0);
        push      = resp_fire && (drop_cnt == '0);
        pop_ok    = fq_pop_en && !fq_empty && (state != S_REDIRECT) && (occ != '0);
        out_nxt   = outstanding + OUT_W'(req_fire) - OUT_W'(resp_fire);
    end

    // Fetch PC: advance on each accepted request, jump to the aligned target on redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pc <= RESET_PC;
        end else if (redirect_valid) begin
            req_pc <= {redirect_pc[31:2], 2'b00};
        end else if (req_fire) begin
            req_pc <= req_pc + 32'd4;
        end
    end

    // Pending-PC FIFO: one entry per outstanding request, popped by every response (kept or dropped).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < MAX_OUT; i++) begin
                pend_pc[i] <= '0;
            end
        end else begin
            if (req_fire) begin
                pend_pc[wr_ptr] <= req_pc;
                wr_ptr          <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (resp_fire) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
        end
    end

    // Outstanding and drop counters; a redirect marks everything still in flight as stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= out_nxt;
            if (redirect_valid) begin
                drop_cnt <= out_nxt;
            end else if (resp_drop) begin
                drop_cnt <= drop_cnt - OUT_W'(1);
            end
        end
    end

    // Fetch-queue occupancy mirror; cleared on redirect together with the queue flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else if (redirect_valid) begin
            occ <= '0;
        end else if (push && !pop_ok) begin
            occ <= occ + OCC_W'(1);
        end else if (!push && pop_ok) begin
            occ <= occ - OCC_W'(1);
        end
    end

    // A response with nothing outstanding breaks the in-order pairing with pending PCs.
    a_resp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
        icache_resp_valid |-> (outstanding != '0));

    // Requests are only issued against free queue credit, so the queue can never overflow.
    a_credit: assert property (@(posedge clk) disable iff (!rst_n)
        (SUM_W'(occ) + SUM_W'(live)) <= QDEPTH_S);

endmodule
